axi_slave_write_engine: RTL



---
 rtl/axi_pkg.sv | 49 ++++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/axi_slave_write_engine.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI constants and queue-entry types for the slave write engine.
//   - BURST_* : awburst encodings
//   - RESP_*  : bresp encodings
//   - aw_cmd_t: one queued AW command (fields sized to the widest supported
//               ID/address; unused upper bits are zero and trim away)
//   - b_ent_t : one queued write response
//   - eng_state_t: burst engine states
// -----------------------------------------------------------------------------
package axi_pkg;

   // Upper limits on ID_W / ADDR_W for the queued structs.
   localparam int AXI_MAX_ID_W   = 32;
   localparam int AXI_MAX_ADDR_W = 64;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [AXI_MAX_ID_W-1:0]   id;
      logic [AXI_MAX_ADDR_W-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                size;
      logic [1:0]                burst;
      logic                      err;
   } aw_cmd_t;

   typedef struct packed {
      logic [AXI_MAX_ID_W-1:0] id;
      logic [1:0]              resp;
   } b_ent_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } eng_state_t;

   // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy count and combinational head.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write an entry (caller guarantees space, or a same-cycle pop)
//   pop, pop_data   : remove the head entry; pop_data is the current head
//   full, empty     : derived from the registered count
// Push and pop in the same cycle are both honoured, including when full.
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Explicit wrap keeps DEPTH==1 (pointer pinned at 0) correct.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);

endmodule

// File: rtl/axi_slave_write_engine.sv
// -----------------------------------------------------------------------------
// axi_slave_write_engine
// AXI4 slave write front end: queued AW commands, FIXED/INCR/WRAP address
// generation scaled by awsize, one beat per cycle on a simple downstream write
// port, queued B responses.
//   clk, rst            : clock, synchronous active-high reset
//   s_axi_aw*           : AW channel (queued, AW_DEPTH entries)
//   s_axi_w*            : W channel (stalled unless a burst is active)
//   s_axi_b*            : B channel (queued, B_DEPTH entries)
//   wr_valid/wr_ready   : downstream beat handshake
//   wr_addr/data/strb/last : downstream beat
//   busy                : engine active or either queue occupied
// Optional feature macro: AXI_WLAST_CHECK_EN -- flags a master whose wlast
// disagrees with the beat count by answering SLVERR for that burst.
// -----------------------------------------------------------------------------
module axi_slave_write_engine
   import axi_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int ID_W     = 12,
   parameter int AW_DEPTH = 2,
   parameter int B_DEPTH  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ID_W-1:0]     s_axi_awid,
   input  logic [ADDR_W-1:0]   s_axi_awaddr,
   input  logic [7:0]          s_axi_awlen,
   input  logic [2:0]          s_axi_awsize,
   input  logic [1:0]          s_axi_awburst,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [DATA_W-1:0]   s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   input  logic                s_axi_wlast,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   output logic [ID_W-1:0]     s_axi_bid,
   output logic [1:0]          s_axi_bresp,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   output logic                wr_valid,
   input  logic                wr_ready,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [DATA_W-1:0]   wr_data,
   output logic [DATA_W/8-1:0] wr_strb,
   output logic                wr_last,
   output logic                busy
);

   localparam int MAX_SIZE = $clog2(DATA_W / 8);

   // ---------------------------------------------------------------- AW queue
   aw_cmd_t aw_in, aw_head;
   logic    aw_push, aw_pop, aw_full, aw_empty;

   always_comb begin
      aw_in       = '0;
      aw_in.id    = AXI_MAX_ID_W'(s_axi_awid);
      aw_in.addr  = AXI_MAX_ADDR_W'(s_axi_awaddr);
      aw_in.len   = s_axi_awlen;
      aw_in.size  = s_axi_awsize;
      aw_in.burst = s_axi_awburst;
      // Illegal commands are still queued so their W data can be drained.
      aw_in.err   = (s_axi_awburst == BURST_RSVD) ||
                    (s_axi_awsize > 3'(MAX_SIZE)) ||
                    ((s_axi_awburst == BURST_WRAP) && !wrap_len_ok(s_axi_awlen));
   end

   assign aw_push = s_axi_awvalid && s_axi_awready;

   sync_fifo #(.WIDTH($bits(aw_cmd_t)), .DEPTH(AW_DEPTH)) u_aw_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (aw_push),
      .push_data (aw_in),
      .pop       (aw_pop),
      .pop_data  (aw_head),
      .full      (aw_full),
      .empty     (aw_empty)
   );

   // ----------------------------------------------------------------- B queue
   b_ent_t b_in, b_head;
   logic   b_push, b_pop, b_full, b_empty;

   assign b_pop = s_axi_bvalid && s_axi_bready;

   sync_fifo #(.WIDTH($bits(b_ent_t)), .DEPTH(B_DEPTH)) u_b_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (b_push),
      .push_data (b_in),
      .pop       (b_pop),
      .pop_data  (b_head),
      .full      (b_full),
      .empty     (b_empty)
   );

   // ------------------------------------------------------------ burst engine
   eng_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        beats_q, beats_d;
   logic [7:0]        len_q, len_d;
   logic [2:0]        size_q, size_d;
   logic [1:0]        burst_q, burst_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              err_q, err_d;
   logic              wlast_err_q, wlast_err_d;
   logic              w_acc, last_beat, wlast_bad;

   logic [ADDR_W-1:0] inc, tot_mask, addr_inc, addr_nxt;

   always_comb begin
      inc      = ADDR_W'(1) << size_q;
      tot_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
      addr_inc = addr_q + inc;
      case (burst_q)
         BURST_INCR: addr_nxt = addr_inc;
         // Stay inside the (len+1)<<size aligned window.
         BURST_WRAP: addr_nxt = (addr_q & ~tot_mask) | (addr_inc & tot_mask);
         default:    addr_nxt = addr_q;
      endcase
   end

   assign last_beat = (beats_q == 8'd0);

`ifdef AXI_WLAST_CHECK_EN
   assign wlast_bad = w_acc && (s_axi_wlast != last_beat);
`else
   assign wlast_bad = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      beats_d      = beats_q;
      len_d        = len_q;
      size_d       = size_q;
      burst_d      = burst_q;
      id_d         = id_q;
      err_d        = err_q;
      wlast_err_d  = wlast_err_q;
      aw_pop       = 1'b0;
      b_push       = 1'b0;
      b_in         = '0;
      s_axi_wready = 1'b0;
      wr_valid     = 1'b0;
      w_acc        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Starting only with a free B slot guarantees the end-of-burst
            // push always has room.
            if (!aw_empty && !b_full) begin
               aw_pop      = 1'b1;
               addr_d      = aw_head.addr[ADDR_W-1:0];
               beats_d     = aw_head.len;
               len_d       = aw_head.len;
               size_d      = aw_head.size;
               burst_d     = aw_head.burst;
               id_d        = aw_head.id[ID_W-1:0];
               err_d       = aw_head.err;
               wlast_err_d = 1'b0;
               state_d     = ST_BURST;
            end
         end
         ST_BURST: begin
            s_axi_wready = err_q ? 1'b1 : wr_ready;
            wr_valid     = !err_q && s_axi_wvalid;
            w_acc        = s_axi_wvalid && s_axi_wready;
            if (w_acc) begin
               addr_d  = addr_nxt;
               beats_d = beats_q - 8'd1;
               if (wlast_bad) wlast_err_d = 1'b1;
               if (last_beat) begin
                  b_push    = 1'b1;
                  b_in.id   = AXI_MAX_ID_W'(id_q);
                  b_in.resp = (err_q || wlast_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                  state_d   = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Reset holds every handshake output low.
      if (rst) begin
         s_axi_wready = 1'b0;
         wr_valid     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         beats_q     <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         id_q        <= '0;
         err_q       <= 1'b0;
         wlast_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         beats_q     <= beats_d;
         len_q       <= len_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         id_q        <= id_d;
         err_q       <= err_d;
         wlast_err_q <= wlast_err_d;
      end
   end

   // ----------------------------------------------------------------- outputs
   assign s_axi_awready = !aw_full && !rst;
   assign s_axi_bvalid  = !b_empty && !rst;
   assign s_axi_bid     = s_axi_bvalid ? b_head.id[ID_W-1:0] : '0;
   assign s_axi_bresp   = s_axi_bvalid ? b_head.resp : RESP_OKAY;

   assign wr_addr = addr_q;
   assign wr_data = s_axi_wdata;
   assign wr_strb = s_axi_wstrb;
   assign wr_last = last_beat;
   assign busy    = (state_q != ST_IDLE) || !aw_empty || !b_empty;

   // Upper struct bits beyond ID_W/ADDR_W are always zero.
   logic unused_bits;
`ifdef AXI_WLAST_CHECK_EN
   assign unused_bits = ^{aw_head, b_head};
`else
   assign unused_bits = ^{aw_head, b_head, s_axi_wlast};
`endif

endmodule
